// File: rtl/cache_pkg.sv
// Shared types and widths for the direct-mapped cache controller.
// Address layout is {tag, index, word}; set operations are encoded as {comp, write}.
package cache_pkg;

  localparam int unsigned TAG_W  = 5;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned WORD_W = 2;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned ADDR_W = TAG_W + IDX_W + WORD_W;

  localparam logic [WORD_W-1:0] LAST_BEAT = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    WB      = 2'd2,
    FILL    = 2'd3
  } state_e;

  // {comp, write}
  typedef enum logic [1:0] {
    OP_ACC_RD  = 2'b00,
    OP_FILL_WR = 2'b01,
    OP_CMP_RD  = 2'b10,
    OP_CMP_WR  = 2'b11
  } set_op_e;

  typedef struct packed {
    logic              we;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
    logic [DATA_W-1:0] wdata;
  } cpu_req_t;

  function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0]  tag,
                                                input logic [IDX_W-1:0]  idx,
                                                input logic [WORD_W-1:0] word);
    return {tag, idx, word};
  endfunction

endpackage

// File: rtl/cache_if.sv
// CPU, set-array and main-memory signals of the cache controller.
// slave = controller view, master = surrounding system (CPU, set array, memory).
interface cache_if;
  import cache_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_busy;

  logic [IDX_W-1:0]  set_index;
  logic              set_enable;
  logic [WORD_W-1:0] set_word;
  logic              set_comp;
  logic              set_write;
  logic              set_valid_in;
  logic [TAG_W-1:0]  set_tag;
  logic [DATA_W-1:0] set_data;
  logic              set_hit;
  logic              set_dirty;
  logic              set_valid;
  logic [TAG_W-1:0]  set_tag_out;
  logic [DATA_W-1:0] set_data_out;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ready, cpu_busy,
    output set_index, set_enable, set_word, set_comp, set_write, set_valid_in, set_tag, set_data,
    input  set_hit, set_dirty, set_valid, set_tag_out, set_data_out,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack,
    output hit_count, miss_count
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ready, cpu_busy,
    input  set_index, set_enable, set_word, set_comp, set_write, set_valid_in, set_tag, set_data,
    output set_hit, set_dirty, set_valid, set_tag_out, set_data_out,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack,
    input  hit_count, miss_count
  );

endinterface

// File: rtl/cache_sat_cnt.sv
// Saturating up-counter: increments on inc, holds at all-ones.
module cache_sat_cnt
  import cache_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencer between the CPU and a direct-mapped array of 4-word sets:
// compare, dirty write-back, line fill with retry, and hit/miss statistics.
module cache_ctrl
  import cache_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  cache_if.slave  bus
);

  state_e            state_q, state_d;
  cpu_req_t          req_q, req_d;
  logic [TAG_W-1:0]  victim_q, victim_d;
  logic [WORD_W-1:0] beat_q, beat_d;
  logic              retry_q, retry_d;
  logic              hit_inc, miss_inc;
  logic              hit_c;
  set_op_e           set_op;

  assign hit_c = bus.set_hit & bus.set_valid;

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      victim_q <= '0;
      beat_q   <= '0;
      retry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      victim_q <= victim_d;
      beat_q   <= beat_d;
      retry_q  <= retry_d;
    end
  end

  // Next state and per-state set/memory controls
  always_comb begin
    state_d          = state_q;
    req_d            = req_q;
    victim_d         = victim_q;
    beat_d           = beat_q;
    retry_d          = retry_q;
    hit_inc          = 1'b0;
    miss_inc         = 1'b0;
    set_op           = OP_ACC_RD;
    bus.cpu_rdata    = '0;
    bus.cpu_ready    = 1'b0;
    bus.cpu_busy     = (state_q != IDLE);
    bus.set_index    = '0;
    bus.set_enable   = 1'b0;
    bus.set_word     = '0;
    bus.set_valid_in = 1'b0;
    bus.set_tag      = '0;
    bus.set_data     = '0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr     = '0;
    bus.mem_wdata    = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.cpu_req) begin
          req_d.we                          = bus.cpu_we;
          {req_d.tag, req_d.idx, req_d.word} = bus.cpu_addr;
          req_d.wdata                       = bus.cpu_wdata;
          retry_d                           = 1'b0;
          state_d                           = COMPARE;
        end
      end

      COMPARE: begin
        bus.set_index  = req_q.idx;
        bus.set_enable = 1'b1;
        set_op         = req_q.we ? OP_CMP_WR : OP_CMP_RD;
        bus.set_word   = req_q.word;
        bus.set_tag    = req_q.tag;
        bus.set_data   = req_q.wdata;
        if (hit_c) begin
          bus.cpu_ready = 1'b1;
          bus.cpu_rdata = req_q.we ? '0 : bus.set_data_out;
          hit_inc       = ~retry_q;
          state_d       = IDLE;
        end else begin
          // Only the first lookup of a request is a statistic; the post-fill retry is not
          miss_inc = ~retry_q;
          victim_d = bus.set_tag_out;
          beat_d   = '0;
          state_d  = (bus.set_valid & bus.set_dirty) ? WB : FILL;
        end
      end

      WB: begin
        bus.set_index  = req_q.idx;
        bus.set_enable = 1'b1;
        set_op         = OP_ACC_RD;
        bus.set_word   = beat_q;
        bus.mem_req    = 1'b1;
        bus.mem_we     = 1'b1;
        bus.mem_addr   = mk_addr(victim_q, req_q.idx, beat_q);
        bus.mem_wdata  = bus.set_data_out;
        if (bus.mem_ack) begin
          beat_d = beat_q + WORD_W'(1);
          if (beat_q == LAST_BEAT) state_d = FILL;
        end
      end

      FILL: begin
        bus.set_index = req_q.idx;
        bus.set_word  = beat_q;
        bus.mem_req   = 1'b1;
        bus.mem_addr  = mk_addr(req_q.tag, req_q.idx, beat_q);
        // Returned word is written into the set in its ack cycle
        if (bus.mem_ack) begin
          bus.set_enable   = 1'b1;
          set_op           = OP_FILL_WR;
          bus.set_data     = bus.mem_rdata;
          bus.set_tag      = req_q.tag;
          bus.set_valid_in = 1'b1;
          beat_d           = beat_q + WORD_W'(1);
          if (beat_q == LAST_BEAT) begin
            retry_d = 1'b1;
            state_d = COMPARE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    {bus.set_comp, bus.set_write} = set_op;
  end

  cache_sat_cnt #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_inc),
    .count (bus.hit_count)
  );

  cache_sat_cnt #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_inc),
    .count (bus.miss_count)
  );

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: set-array and memory environment, abstract cache model
// with a per-cycle compare process, and directed accesses with literal expectations.
module tb_cache_ctrl;
  import cache_pkg::*;

  localparam int unsigned NSETS = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_if bus ();

  cache_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic       sat_inc;
  logic [3:0] sat_val;
  cache_sat_cnt #(.W(4)) u_sat (
    .clk   (clk),
    .rst   (rst),
    .inc   (sat_inc),
    .count (sat_val)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic fail_event(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual %0h, required no such event", name, act);
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } mem_op_t;

  // ---------------- environment: set array ----------------
  logic              sv_valid [NSETS]    = '{default: 1'b0};
  logic              sv_dirty [NSETS]    = '{default: 1'b0};
  logic [TAG_W-1:0]  sv_tag   [NSETS]    = '{default: '0};
  logic [DATA_W-1:0] sv_data  [NSETS][4] = '{default: '0};

  always_comb begin
    bus.set_valid    = sv_valid[bus.set_index];
    bus.set_dirty    = sv_dirty[bus.set_index];
    bus.set_tag_out  = sv_tag[bus.set_index];
    bus.set_data_out = sv_data[bus.set_index][bus.set_word];
    bus.set_hit      = (sv_tag[bus.set_index] == bus.set_tag);
  end

  always @(posedge clk) begin
    if (bus.set_enable && bus.set_write) begin
      if (bus.set_comp) begin
        if (sv_valid[bus.set_index] && sv_tag[bus.set_index] == bus.set_tag) begin
          sv_data[bus.set_index][bus.set_word] <= bus.set_data;
          sv_dirty[bus.set_index]              <= 1'b1;
        end
      end else begin
        sv_data[bus.set_index][bus.set_word] <= bus.set_data;
        sv_tag[bus.set_index]                <= bus.set_tag;
        sv_valid[bus.set_index]              <= bus.set_valid_in;
        sv_dirty[bus.set_index]              <= 1'b0;
      end
    end
  end

  // ---------------- environment: main memory ----------------
  logic [DATA_W-1:0] env_mem [bit [ADDR_W-1:0]];
  mem_op_t           env_log [$];
  int                ack_delay = 0;
  int                wcnt;

  function automatic logic [DATA_W-1:0] dflt_mem(input logic [ADDR_W-1:0] a);
    return 16'h1000 + DATA_W'(a[WORD_W-1:0]);
  endfunction

  function automatic logic [DATA_W-1:0] env_rd(input logic [ADDR_W-1:0] a);
    if (env_mem.exists(a)) return env_mem[a];
    return dflt_mem(a);
  endfunction

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    wcnt          = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst || !bus.mem_req) begin
        bus.mem_ack = 1'b0;
        wcnt        = 0;
      end else begin
        if (bus.mem_ack) wcnt = 0;
        if (wcnt >= ack_delay) begin
          bus.mem_ack   = 1'b1;
          bus.mem_rdata = bus.mem_we ? '0 : env_rd(bus.mem_addr);
        end else begin
          bus.mem_ack = 1'b0;
          wcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.mem_req && bus.mem_ack) begin
      env_log.push_back('{we: bus.mem_we, addr: bus.mem_addr,
                          data: bus.mem_we ? bus.mem_wdata : bus.mem_rdata});
      if (bus.mem_we) env_mem[bus.mem_addr] = bus.mem_wdata;
    end
  end

  // ---------------- reference model: abstract cache ----------------
  logic              m_valid [NSETS]    = '{default: 1'b0};
  logic              m_dirty [NSETS]    = '{default: 1'b0};
  logic [TAG_W-1:0]  m_tag   [NSETS]    = '{default: '0};
  logic [DATA_W-1:0] m_line  [NSETS][4] = '{default: '0};
  logic [DATA_W-1:0] m_mem   [bit [ADDR_W-1:0]];
  mem_op_t           exp_ops [$];
  logic              exp_pending = 1'b0;
  logic              exp_we      = 1'b0;
  logic              exp_first_hit = 1'b0;
  logic [DATA_W-1:0] exp_rdata   = '0;
  int                m_hits      = 0;
  int                m_misses    = 0;

  task automatic model_req(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata);
    logic [TAG_W-1:0]  t;
    logic [IDX_W-1:0]  i;
    logic [WORD_W-1:0] w;
    logic [ADDR_W-1:0] a;
    {t, i, w} = addr;
    exp_first_hit = m_valid[i] && (m_tag[i] == t);
    if (!exp_first_hit) begin
      if (m_valid[i] && m_dirty[i]) begin
        for (int b = 0; b < 4; b++) begin
          a = {m_tag[i], i, WORD_W'(b)};
          exp_ops.push_back('{we: 1'b1, addr: a, data: m_line[i][b]});
          m_mem[a] = m_line[i][b];
        end
      end
      for (int b = 0; b < 4; b++) begin
        a = {t, i, WORD_W'(b)};
        exp_ops.push_back('{we: 1'b0, addr: a, data: '0});
        m_line[i][b] = m_mem.exists(a) ? m_mem[a] : dflt_mem(a);
      end
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_dirty[i] = 1'b0;
    end
    if (we) begin
      m_line[i][w] = wdata;
      m_dirty[i]   = 1'b1;
    end
    exp_rdata   = m_line[i][w];
    exp_we      = we;
    exp_pending = 1'b1;
  endtask

  // ---------------- per-cycle compare ----------------
  logic              prev_req = 1'b0;
  logic              prev_ack = 1'b0;
  logic              prev_we  = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0;
  logic [DATA_W-1:0] prev_wdata = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_ops.delete();
      exp_pending = 1'b0;
      m_hits      = 0;
      m_misses    = 0;
      prev_req    = 1'b0;
    end else begin
      if (prev_req && !prev_ack && bus.mem_req) begin
        chk("mem_addr_stable", 32'(bus.mem_addr), 32'(prev_addr));
        chk("mem_we_stable", 32'(bus.mem_we), 32'(prev_we));
        if (bus.mem_we) chk("mem_wdata_stable", 32'(bus.mem_wdata), 32'(prev_wdata));
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (exp_ops.size() == 0) begin
          fail_event("mem_unexpected_beat", 32'(bus.mem_addr));
        end else begin
          mem_op_t op;
          op = exp_ops.pop_front();
          chk("mem_we", 32'(bus.mem_we), 32'(op.we));
          chk("mem_addr", 32'(bus.mem_addr), 32'(op.addr));
          if (op.we) chk("mem_wdata", 32'(bus.mem_wdata), 32'(op.data));
        end
      end
      if (!bus.cpu_busy) begin
        chk("idle_ctrl", 32'({bus.set_enable, bus.mem_req, bus.cpu_ready,
                              bus.set_comp, bus.set_write, bus.set_valid_in}), 32'h0);
        chk("idle_set_data", 32'({bus.set_tag, bus.set_data}), 32'h0);
        chk("hit_count", 32'(bus.hit_count), 32'(m_hits));
        chk("miss_count", 32'(bus.miss_count), 32'(m_misses));
      end
      if (bus.cpu_ready) begin
        if (!exp_pending) begin
          fail_event("cpu_ready_unexpected", 32'(bus.cpu_rdata));
        end else begin
          chk("ops_done_at_ready", 32'(exp_ops.size()), 32'h0);
          chk("busy_at_ready", 32'(bus.cpu_busy), 32'h1);
          chk("compare_op", 32'({bus.set_enable, bus.set_comp, bus.set_write}),
              32'({2'b11, exp_we}));
          if (!exp_we) chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_rdata));
          exp_pending = 1'b0;
          if (exp_first_hit) begin
            if (m_hits < 32'hFFFF) m_hits++;
          end else begin
            if (m_misses < 32'hFFFF) m_misses++;
          end
        end
      end
      prev_req   = bus.mem_req;
      prev_ack   = bus.mem_ack;
      prev_we    = bus.mem_we;
      prev_addr  = bus.mem_addr;
      prev_wdata = bus.mem_wdata;
    end
  end

  // ---------------- driver ----------------
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input bit pulse,
                            output int lat, output logic [DATA_W-1:0] rd);
    bit done;
    done = 1'b0;
    rd   = '0;
    env_log.delete();
    model_req(we, addr, wdata);
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    bus.cpu_req   = 1'b1;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    lat = 0;
    while (!done && lat < 400) begin
      @(negedge clk);
      lat++;
      if (bus.cpu_ready) begin
        rd   = bus.cpu_rdata;
        done = 1'b1;
      end else if (pulse && lat == 3) begin
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 15'h284C;
        bus.cpu_req  = 1'b1;
      end else if (pulse && lat == 4) begin
        bus.cpu_req = 1'b0;
      end
    end
    if (!done) fail_event("cpu_ready_timeout", 32'(addr));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  int                lat;
  logic [DATA_W-1:0] rd;
  logic [DATA_W-1:0] ev_data [4] = '{16'h1000, 16'h1001, 16'hBEEF, 16'h1003};
  logic [DATA_W-1:0] ev2_data[4] = '{16'h1000, 16'h1001, 16'h1002, 16'h5A5A};
  bit                found;

  initial begin
    rst           = 1'b1;
    sat_inc       = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({bus.cpu_ready, bus.cpu_busy, bus.mem_req, bus.mem_we,
                         bus.set_enable, bus.set_comp, bus.set_write, bus.set_valid_in}), 32'h0);
    chk("rst_counts", 32'({bus.hit_count, bus.miss_count}), 32'h0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'h0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset in the middle of a line fill (tag 1, idx 0x20 is never used again)
    model_req(1'b0, 15'h0480, '0);
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 15'h0480;
    bus.cpu_req  = 1'b1;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 100 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_req && !bus.mem_we && bus.mem_addr[1:0] == 2'd2) found = 1'b1;
    end
    if (!found) fail_event("fill_beat2_timeout", 32'(bus.mem_addr));
    chk("miss_count_before_rst", 32'(bus.miss_count), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_async_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_async_busy", 32'(bus.cpu_busy), 32'h0);
    chk("rst_async_set_enable", 32'(bus.set_enable), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_counts", 32'({bus.hit_count, bus.miss_count}), 32'h0);
    chk("post_rst_busy", 32'(bus.cpu_busy), 32'h0);

    // Cold read miss: tag 3, idx 0x10, word 2
    cpu_access(1'b0, 15'h0C42, '0, 1'b0, lat, rd);
    chk("cold_rdata", 32'(rd), 32'h1002);
    chk("cold_beats", 32'(env_log.size()), 32'd4);
    if (env_log.size() == 4)
      for (int b = 0; b < 4; b++) begin
        chk("cold_fill_addr", 32'(env_log[b].addr), 32'h0C40 + 32'(b));
        chk("cold_fill_we", 32'(env_log[b].we), 32'h0);
      end
    chk("cold_hit_count", 32'(bus.hit_count), 32'h0);
    chk("cold_miss_count", 32'(bus.miss_count), 32'h1);

    // Write hit, same address
    cpu_access(1'b1, 15'h0C42, 16'hBEEF, 1'b0, lat, rd);
    chk("wr_hit_latency", 32'(lat), 32'h1);
    chk("wr_hit_no_mem", 32'(env_log.size()), 32'h0);
    chk("wr_hit_count", 32'(bus.hit_count), 32'h1);

    // Dirty eviction by tag 7, same index
    cpu_access(1'b0, 15'h1C40, '0, 1'b0, lat, rd);
    chk("evict_rdata", 32'(rd), 32'h1000);
    chk("evict_beats", 32'(env_log.size()), 32'd8);
    if (env_log.size() == 8)
      for (int b = 0; b < 4; b++) begin
        chk("evict_wb_addr", 32'(env_log[b].addr), 32'h0C40 + 32'(b));
        chk("evict_wb_we", 32'(env_log[b].we), 32'h1);
        chk("evict_wb_data", 32'(env_log[b].data), 32'(ev_data[b]));
        chk("evict_fill_addr", 32'(env_log[b+4].addr), 32'h1C40 + 32'(b));
        chk("evict_fill_we", 32'(env_log[b+4].we), 32'h0);
      end
    chk("evict_miss_count", 32'(bus.miss_count), 32'h2);

    // Read hit on the refilled line
    cpu_access(1'b0, 15'h1C43, '0, 1'b0, lat, rd);
    chk("rd_hit_latency", 32'(lat), 32'h1);
    chk("rd_hit_rdata", 32'(rd), 32'h1003);
    chk("rd_hit_count", 32'(bus.hit_count), 32'h2);

    // Slow memory with a stray request pulse while busy
    ack_delay = 5;
    cpu_access(1'b0, 15'h2445, '0, 1'b1, lat, rd);
    ack_delay = 0;
    chk("slow_rdata", 32'(rd), 32'h1001);
    repeat (20) @(posedge clk);
    #1;
    chk("stray_req_ignored_beats", 32'(env_log.size()), 32'd4);
    chk("stray_req_busy", 32'(bus.cpu_busy), 32'h0);
    chk("slow_miss_count", 32'(bus.miss_count), 32'h3);

    // Write miss, readback, then dirty eviction of the written line
    cpu_access(1'b1, 15'h084B, 16'h5A5A, 1'b0, lat, rd);
    chk("wr_miss_counts", 32'({bus.hit_count, bus.miss_count}), 32'h0002_0004);
    cpu_access(1'b0, 15'h084B, '0, 1'b0, lat, rd);
    chk("wr_miss_readback", 32'(rd), 32'h5A5A);
    cpu_access(1'b0, 15'h084A, '0, 1'b0, lat, rd);
    chk("wr_miss_neighbour", 32'(rd), 32'h1002);
    cpu_access(1'b0, 15'h1048, '0, 1'b0, lat, rd);
    chk("evict2_beats", 32'(env_log.size()), 32'd8);
    if (env_log.size() == 8)
      for (int b = 0; b < 4; b++) begin
        chk("evict2_wb_addr", 32'(env_log[b].addr), 32'h0848 + 32'(b));
        chk("evict2_wb_data", 32'(env_log[b].data), 32'(ev2_data[b]));
      end
    chk("final_counts", 32'({bus.hit_count, bus.miss_count}), 32'h0004_0005);

    // Saturation of the counter block
    sat_inc = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("sat_mid", 32'(sat_val), 32'd10);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_hold", 32'(sat_val), 32'hF);
    sat_inc = 1'b0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
